// File: rtl/seg7_pkg.sv
// Glyph constants and the hex-to-segment lookup shared by the scan driver.
// Patterns are high-true, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble-to-glyph decoder; output is high-true, polarity is
// applied by whoever instantiates it.
module hex7seg_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_high
);

    assign seg_high = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: shadow-latches the value, scans one
// digit per prescaler period and registers segment/anode outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                lz_blank,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     COUNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0]     INDEX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV    = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_INV     = {DIGITS{ACTIVE_LOW}};

    logic [4*DIGITS-1:0] shadow_value_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [CW-1:0]       count_reg, count_next;
    logic [IW-1:0]       index_reg, index_next;
    logic                wrap_reg, wrap_next;
    logic [6:0]          seg_reg, seg_next;
    logic                dp_reg, dp_next;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic                frame_done_reg;

    logic                tick;
    logic [3:0]          nibble_arr [DIGITS];
    logic [DIGITS:0]     zero_from;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_seg_high;
    logic                cur_blank;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
        assign nibble_arr[gi] = shadow_value_reg[4*gi +: 4];
    end

    // zero_from[k] is set when every nibble from k up to the top digit is zero.
    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] & (nibble_arr[k] == 4'h0);
        end
    end

    always_comb begin
        tick       = (count_reg == COUNT_LAST);
        count_next = tick ? '0 : count_reg + CW'(1);
        index_next = index_reg;
        if (tick) begin
            index_next = (index_reg == INDEX_LAST) ? '0 : index_reg + IW'(1);
        end
        wrap_next  = tick && (index_reg == INDEX_LAST);
    end

    assign cur_nibble = nibble_arr[index_reg];

    hex7seg_decoder u_decoder (
        .nibble   (cur_nibble),
        .seg_high (cur_seg_high)
    );

    always_comb begin
        cur_blank = lz_blank && (index_reg != '0) && zero_from[index_reg];
        seg_next  = (cur_blank ? SEG_BLANK : cur_seg_high) ^ SEG_INV;
        dp_next   = shadow_dp_reg[index_reg] ^ ACTIVE_LOW;
        an_next   = (DIGITS'(1) << index_reg) ^ AN_INV;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            count_reg        <= '0;
            index_reg        <= '0;
            wrap_reg         <= 1'b0;
            seg_reg          <= SEG_INV;
            dp_reg           <= ACTIVE_LOW;
            an_reg           <= AN_INV;
            frame_done_reg   <= 1'b0;
        end else begin
            if (load) begin
                shadow_value_reg <= value;
                shadow_dp_reg    <= dp_in;
            end
            count_reg      <= count_next;
            index_reg      <= index_next;
            wrap_reg       <= wrap_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            // Delayed by one stage so the pulse lines up with an showing digit 0.
            frame_done_reg <= wrap_reg;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIGITS=4, PRESCALE=4, ACTIVE_LOW=1.
module tb_seg7_scan_driver;

    logic        clock;
    logic        resetn;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_driver #(
        .DIGITS     (4),
        .PRESCALE   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // High-true glyphs a..g, index = nibble.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;   // clock edges since reset release
    logic [15:0] m_val      = '0;
    logic [3:0]  m_dp       = '0;
    logic [12:0] obs;              // {an, seg, dp, frame_done}
    logic [12:0] sb [$];

    function automatic logic [12:0] model_out(input int d, input logic [15:0] v,
                                              input logic [3:0] dpv, input logic lz,
                                              input logic fd);
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [6:0]  s;
        logic [3:0]  a;
        upper = v >> (4 * d);
        nib   = upper[3:0];
        s     = (lz && d != 0 && upper == 16'h0) ? 7'h00 : glyph[nib];
        a     = 4'b0001 << d;
        return {~a, ~s, ~dpv[d], fd};
    endfunction

    // Drive one cycle of stimulus, push the expected post-edge outputs, sample at negedge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
        load = ld; value = v; dp_in = d; lz_blank = lz;
        sb.push_back(model_out((cyc / 4) % 4, m_val, m_dp, lz, (cyc >= 16) && (cyc % 16 == 0)));
        @(posedge clock);
        if (ld) begin
            m_val = v;
            m_dp  = d;
        end
        cyc++;
        @(negedge clock);
        obs = {an, seg, dp, frame_done};
        $display("t=%0t cyc=%0d ld=%0b val=%h dp_in=%b lz=%0b -> an=%b seg=%h dp=%b fd=%b",
                 $time, cyc, ld, v, d, lz, an, seg, dp, frame_done);
    endtask

    task automatic test_reset();
        logic [12:0] e;
        load = 0; value = '0; dp_in = '0; lz_blank = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #2;
        vectors++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected %h", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected %h", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        resetn = 1'b1;
        cyc = 0; m_val = '0; m_dp = '0;
        step(0, 16'h0, 4'h0, 0);
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_first_scan: got %h expected %h", obs, e);
        end
        vectors++;
        if (an !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_first_an: got %b expected 1110", an);
        end
    endtask

    task automatic test_basic_scan();
        logic [12:0] e;
        logic [6:0]  exp_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        int          d;
        step(1, 16'h12AF, 4'b0100, 0);
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL basic_load: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
            d = ((cyc - 1) / 4) % 4;
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL basic_scan: got %h expected %h", obs, e);
            end
            vectors++;
            if ({seg, dp} !== {exp_seg[d], (d == 2) ? 1'b0 : 1'b1}) begin
                miscompares++;
                $display("FAIL basic_glyph d%0d: got seg=%h dp=%b expected seg=%h dp=%b",
                         d, seg, dp, exp_seg[d], (d == 2) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [12:0] e;
        logic [6:0]  tbl0030 [4] = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        logic [6:0]  want;
        int          d;
        for (int phase = 0; phase < 2; phase++) begin
            step(1, (phase == 0) ? 16'h0030 : 16'h0000, 4'h0, 1);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL lz_load: got %h expected %h", obs, e);
            end
            for (int i = 0; i < 16; i++) begin
                step(0, 16'h0, 4'h0, 1);
                e = sb.pop_front();
                d = ((cyc - 1) / 4) % 4;
                want = (phase == 0) ? tbl0030[d] : ((d == 0) ? 7'h40 : 7'h7F);
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL lz_scan: got %h expected %h", obs, e);
                end
                vectors++;
                if (seg !== want) begin
                    miscompares++;
                    $display("FAIL lz_glyph d%0d: got %h expected %h", d, seg, want);
                end
            end
        end
    endtask

    task automatic test_frame_pulse();
        logic [12:0] e;
        int          pulses = 0;
        int          last   = -1;
        for (int i = 0; i < 64; i++) begin
            step(0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL frame_scan: got %h expected %h", obs, e);
            end
            if (frame_done === 1'b1) begin
                pulses++;
                vectors++;
                if (an !== 4'b1110) begin
                    miscompares++;
                    $display("FAIL frame_an: got %b expected 1110", an);
                end
                if (last >= 0) begin
                    vectors++;
                    if (i - last !== 16) begin
                        miscompares++;
                        $display("FAIL frame_spacing: got %0d expected 16", i - last);
                    end
                end
                last = i;
            end
        end
        vectors++;
        if (pulses !== 4) begin
            miscompares++;
            $display("FAIL frame_count: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_mid_frame_load();
        logic [12:0] e;
        bit          found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (((cyc - 1) / 4) % 4 == 2 && (cyc / 4) % 4 == 2) begin
                found = 1;
            end else begin
                step(0, 16'h0, 4'h0, 0);
                e = sb.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL mid_pre: got %h expected %h", obs, e);
                end
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_find_digit2: got none expected digit 2 within 20 cycles");
        end
        step(1, 16'h8888, 4'h0, 0);
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL mid_load: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mid_scan: got %h expected %h", obs, e);
            end
            if (i == 0) begin
                vectors++;
                if ({an, seg} !== {4'b1011, 7'h00}) begin
                    miscompares++;
                    $display("FAIL mid_glyph: got an=%b seg=%h expected an=1011 seg=00", an, seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        bit          found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (((cyc - 1) / 4) % 4 == 3) begin
                found = 1;
            end else begin
                step(0, 16'h0, 4'h0, 0);
                e = sb.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL rstmid_pre: got %h expected %h", obs, e);
                end
            end
        end
        vectors++;
        if (!found || an !== 4'b0111) begin
            miscompares++;
            $display("FAIL rstmid_find_digit3: got an=%b expected 0111", an);
        end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h expected %h", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        cyc = 0; m_val = '0; m_dp = '0;
        for (int i = 0; i < 8; i++) begin
            step(0, 16'h0, 4'h0, 0);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL rstmid_scan: got %h expected %h", obs, e);
            end
            if (i == 0) begin
                vectors++;
                if ({an, seg} !== {4'b1110, 7'h40}) begin
                    miscompares++;
                    $display("FAIL rstmid_restart: got an=%b seg=%h expected an=1110 seg=40", an, seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_frame_pulse();
        test_mid_frame_load();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
